// File: rtl/system_bus_pkg.sv
// ============================================================================
// system_bus_pkg : shared types and default memory map for system_bus_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

package system_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACKW = 2'd2,
    HOLD = 2'd3
  } bus_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_RDWR     = 2'b11;

  // Default map: RAM 00000-03FFF, ROM FC000-FFFFF, PIC IO 0x2x, PIT IO 0x4x
  localparam logic [79:0] C_SLV_BASE    = {20'h00040, 20'h00020, 20'hFC000, 20'h00000};
  localparam logic [79:0] C_SLV_MASK    = {20'h000F0, 20'h000F0, 20'hFC000, 20'hFC000};
  localparam logic [3:0]  C_SLV_IO      = 4'b1100;
  localparam logic [15:0] C_SLV_WAIT    = {4'd2, 4'd0, 4'd1, 4'd0};
  localparam logic [3:0]  C_SLV_USE_ACK = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/system_bus_ctrl_decoder.sv
// ============================================================================
// bus_addr_decoder : combinational slave window decode, lowest index wins
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_addr_decoder
  import system_bus_pkg::*;
#(
  parameter int                      ADDR_W   = 20,
  parameter int                      N_SLV    = 4,
  parameter int                      IDX_W    = 2,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = C_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = C_SLV_MASK,
  parameter logic [N_SLV-1:0]        SLV_IO   = C_SLV_IO,
  parameter int                      INTA_SLV = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              iom,
  input  logic              inta,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [N_SLV-1:0]  sel
);

  logic [N_SLV-1:0] match;

  generate
    for (genvar i = 0; i < N_SLV; i++) begin : g_match
      assign match[i] = (iom == SLV_IO[i]) &&
                        ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
    end
  endgenerate

  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (inta) begin
      hit = 1'b1;
      idx = IDX_W'(INTA_SLV);
    end else begin
      // Scan downwards so the lowest matching index is the last one written
      for (int i = N_SLV - 1; i >= 0; i--) begin
        if (match[i]) begin
          hit = 1'b1;
          idx = IDX_W'(i);
        end
      end
    end
  end

  assign sel = hit ? (N_SLV'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/system_bus_ctrl.sv
// ============================================================================
// system_bus_ctrl : clocked 8088 bus glue with decode, wait states, ack
//                   timeout, registered read data and sticky error log
// Revision 1.0
// ============================================================================
`default_nettype none

module system_bus_ctrl
  import system_bus_pkg::*;
#(
  parameter int                      ADDR_W       = 20,
  parameter int                      DATA_W       = 8,
  parameter int                      N_SLV        = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE     = C_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK     = C_SLV_MASK,
  parameter logic [N_SLV-1:0]        SLV_IO       = C_SLV_IO,
  parameter logic [N_SLV*4-1:0]      SLV_WAIT     = C_SLV_WAIT,
  parameter logic [N_SLV-1:0]        SLV_USE_ACK  = C_SLV_USE_ACK,
  parameter int                      INTA_SLV     = 1,
  parameter int                      TIMEOUT      = 64,
  parameter logic [DATA_W-1:0]       DEFAULT_DATA = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd_n,
  input  logic                    cpu_wr_n,
  input  logic                    cpu_iom,
  input  logic                    cpu_inta_n,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_dout,
  output logic [DATA_W-1:0]       cpu_din,
  output logic                    cpu_ready,
  output logic [N_SLV-1:0]        slv_sel,
  output logic                    slv_rd,
  output logic                    slv_wr,
  output logic [ADDR_W-1:0]       slv_addr,
  output logic [DATA_W-1:0]       slv_wdata,
  input  logic [N_SLV*DATA_W-1:0] slv_rdata,
  input  logic [N_SLV-1:0]        slv_ack,
  output logic                    bus_err,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [1:0]              err_code,
  input  logic                    err_clr
);

  localparam int               IDX_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int               TOC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TOC_W-1:0] TOC_LAST = TOC_W'(TIMEOUT - 1);

  bus_state_t       state;
  logic             rd_q, wr_q, inta_q;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_wr;
  logic [3:0]       cnt;
  logic [TOC_W-1:0] toc;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [N_SLV-1:0] dec_sel;

  logic              start, is_write, is_rdwr;
  logic              ack_cur, need_ack;
  logic [DATA_W-1:0] rdata_cur;
  logic [3:0]        wait_load;

  logic              err_event;
  logic [1:0]        err_event_code;
  logic [ADDR_W-1:0] err_event_addr;

  bus_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .N_SLV    (N_SLV),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .SLV_IO   (SLV_IO),
    .INTA_SLV (INTA_SLV)
  ) u_dec (
    .addr (cpu_addr),
    .iom  (cpu_iom),
    .inta (~cpu_inta_n),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .sel  (dec_sel)
  );

  assign start = (state == IDLE) &&
                 ((~cpu_rd_n & rd_q) | (~cpu_wr_n & wr_q) | (~cpu_inta_n & inta_q));
  assign is_write  = ~cpu_wr_n;
  assign is_rdwr   = ~cpu_rd_n & ~cpu_wr_n;
  assign ack_cur   = slv_ack[cur_idx];
  assign need_ack  = SLV_USE_ACK[cur_idx];
  assign rdata_cur = slv_rdata[cur_idx*DATA_W +: DATA_W];
  assign wait_load = SLV_WAIT[dec_idx*4 +: 4];

  always_comb begin
    err_event      = 1'b0;
    err_event_code = ERR_NONE;
    err_event_addr = '0;
    if (start && is_rdwr) begin
      err_event      = 1'b1;
      err_event_code = ERR_RDWR;
      err_event_addr = cpu_addr;
    end else if (start && !dec_hit) begin
      err_event      = 1'b1;
      err_event_code = ERR_UNMAPPED;
      err_event_addr = cpu_addr;
    end else if (state == ACKW && !ack_cur && toc == TOC_LAST) begin
      err_event      = 1'b1;
      err_event_code = ERR_TIMEOUT;
      err_event_addr = slv_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      inta_q    <= 1'b1;
      cur_idx   <= '0;
      cur_wr    <= 1'b0;
      cnt       <= 4'd0;
      toc       <= '0;
      cpu_ready <= 1'b1;
      cpu_din   <= DEFAULT_DATA;
      slv_sel   <= '0;
      slv_rd    <= 1'b0;
      slv_wr    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      rd_q   <= cpu_rd_n;
      wr_q   <= cpu_wr_n;
      inta_q <= cpu_inta_n;
      slv_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cpu_ready <= 1'b0;
            if (dec_hit) begin
              state     <= WAIT;
              slv_addr  <= cpu_addr;
              slv_wdata <= cpu_dout;
              cnt       <= wait_load;
              slv_sel   <= dec_sel;
              slv_rd    <= ~is_write;
              slv_wr    <= is_write;
              cur_idx   <= dec_idx;
              cur_wr    <= is_write;
            end else begin
              state   <= HOLD;
              cpu_din <= DEFAULT_DATA;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!need_ack || ack_cur) begin
              if (!cur_wr) cpu_din <= rdata_cur;
              cpu_ready <= 1'b1;
              slv_sel   <= '0;
              slv_rd    <= 1'b0;
              state     <= HOLD;
            end else begin
              toc   <= '0;
              state <= ACKW;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACKW: begin
          if (ack_cur || toc == TOC_LAST) begin
            if (!cur_wr) cpu_din <= ack_cur ? rdata_cur : DEFAULT_DATA;
            cpu_ready <= 1'b1;
            slv_sel   <= '0;
            slv_rd    <= 1'b0;
            state     <= HOLD;
          end else if (toc != '1) begin
            toc <= toc + 1'b1;
          end
        end
        HOLD: begin
          cpu_ready <= 1'b1;
          slv_sel   <= '0;
          slv_rd    <= 1'b0;
          if (cpu_rd_n && cpu_wr_n && cpu_inta_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // First error wins; a clear in the same cycle as a new error keeps the new one
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (err_clr) begin
        bus_err  <= 1'b0;
        err_addr <= '0;
        err_code <= ERR_NONE;
      end
      if (err_event && (!bus_err || err_clr)) begin
        bus_err  <= 1'b1;
        err_addr <= err_event_addr;
        err_code <= err_event_code;
      end
    end
  end

endmodule

`default_nettype wire
